// File: rtl/filter_pkg.sv
// Shared constants and helpers for the filter sample FIFO slice.
package filter_pkg;
   localparam int WIDTH_DEF  = 16;
   localparam int SETTLE_DEF = 3;

   // Unsigned subtract that clamps at zero instead of wrapping.
   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) ? (a - b) : 32'd0;
   endfunction

   // One extra pointer bit distinguishes full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/filter_sample_fifo_if.sv
// Valid/ready read port carrying the FIFO head word to host-side logic.
interface filter_sample_fifo_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sample_fifo.sv
// Sample FIFO: storage, wrap-around pointers, fill level and sticky overflow.
module sample_fifo
   import filter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_req,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     ovf,
   input  logic                     ovf_clr
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             pop;
   logic             wr_en;

   assign fill     = wr_ptr - rd_ptr;
   assign full     = (fill == PW'(DEPTH));
   assign empty    = (fill == '0);
   assign pop      = pop_req && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr_en    = push && (!full || pop);
   assign rd_valid = !empty;
   assign rd_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
      end
   end
endmodule

// File: rtl/filter_sample_fifo.sv
// Captures sinc3 decimator words on word_clk edges, drops the settling transient,
// offset-corrects with zero clamp and buffers in a FIFO. FILTER_SAMPLE_AVG_EN adds 4-word averaging.
module filter_sample_fifo
   import filter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DEPTH  = 16,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     word_clk,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [WIDTH-1:0]         offset,
   filter_sample_fifo_if.master     rd,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     ovf,
   input  logic                     ovf_clr
);
   localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   logic             sync1, sync2, sync3;
   logic             cap_pulse;
   logic [WIDTH-1:0] corr;
   logic [WIDTH-1:0] cap_reg;
   logic             cap_vld;
   logic [SW-1:0]    settle_cnt;
   logic             settled;
   logic             accept;
   logic             push;
   logic [WIDTH-1:0] push_data;

   assign cap_pulse = sync2 & ~sync3;
   assign corr      = WIDTH'(sat_sub(32'(data_in), 32'(offset)));
   assign settled   = (settle_cnt >= SW'(SETTLE));
   assign accept    = cap_vld && settled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync3      <= 1'b0;
         cap_reg    <= '0;
         cap_vld    <= 1'b0;
         settle_cnt <= '0;
      end else begin
         sync1   <= word_clk;
         sync2   <= sync1;
         sync3   <= sync2;
         cap_vld <= cap_pulse;
         if (cap_pulse) cap_reg <= corr;
         if (cap_vld && !settled) settle_cnt <= settle_cnt + 1'b1;
      end
   end

`ifdef FILTER_SAMPLE_AVG_EN
   logic [WIDTH+1:0] acc;
   logic [WIDTH+1:0] sum;
   logic [1:0]       phase;

   // Fourth word is folded in combinationally so the push keeps the plain-path latency.
   assign sum       = acc + {2'b00, cap_reg};
   assign push      = accept && (phase == 2'd3);
   assign push_data = sum[WIDTH+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         phase <= 2'd0;
      end else if (accept) begin
         phase <= phase + 2'd1;
         acc   <= (phase == 2'd3) ? '0 : sum;
      end
   end
`else
   assign push      = accept;
   assign push_data = cap_reg;
`endif

   sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop_req   (rd.out_ready),
      .rd_data   (rd.out_data),
      .rd_valid  (rd.out_valid),
      .fill      (fill),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );
endmodule
